// File: rtl/carry_lookahead_adder_pipe.sv
// -----------------------------------------------------------------------------
// carry_lookahead_adder_pipe
//   Pipelined carry-lookahead add/subtract unit with valid/ready streaming on
//   both sides. The lookahead (bit P/G -> group P/G -> group carries -> sum)
//   is evaluated in front of stage 0 and the result then travels through
//   G_STAGES register stages. The accept edge loads stage 0, so a result
//   crosses G_STAGES clock edges (the accept edge included) before o_valid
//   rises at the output of the last stage.
//
// Parameters
//   G_WIDTH   operand width (>= 2)
//   G_GROUP   bits per lookahead group (last group may be partial)
//   G_STAGES  number of pipeline register stages (1..4)
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       operand handshake (o_ready is combinational)
//   i_add1, i_add2          operands A and B
//   i_carry                 carry-in, used in add mode only
//   i_sub                   1: A - B, 0: A + B + i_carry
//   o_valid / i_ready       result handshake
//   o_result                {carry_out, sum}
//   o_overflow              two's-complement overflow of the sum
//   o_txn_count             output transfer count, present only when
//                           CLA_ADDER_PIPE_STATS_EN is defined
// -----------------------------------------------------------------------------
module carry_lookahead_adder_pipe #(
    parameter int G_WIDTH  = 8,
    parameter int G_GROUP  = 4,
    parameter int G_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [G_WIDTH-1:0] i_add1,
    input  logic [G_WIDTH-1:0] i_add2,
    input  logic               i_carry,
    input  logic               i_sub,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [G_WIDTH:0]   o_result,
    output logic               o_overflow
`ifdef CLA_ADDER_PIPE_STATS_EN
    ,
    output logic [15:0]        o_txn_count
`endif
);

    localparam int NG   = (G_WIDTH + G_GROUP - 1) / G_GROUP;
    localparam int LAST = G_STAGES - 1;

    // ------------------------------------------------------------------
    // Lookahead datapath
    // ------------------------------------------------------------------
    logic [G_WIDTH-1:0] b_eff;
    logic [G_WIDTH-1:0] bit_p;
    logic [G_WIDTH-1:0] bit_g;
    logic               cin;
    logic [NG-1:0]      grp_g;
    logic [NG-1:0]      grp_p;
    logic [NG:0]        grp_c;
    logic [G_WIDTH-1:0] sum_d;
    logic               ovf_d;
    logic               la_term;
    logic               la_prod;
    logic               bit_c;

    // Subtraction is A + ~B + 1, so the carry-in is forced high and i_carry
    // has no effect in that mode.
    assign b_eff = i_sub ? ~i_add2 : i_add2;
    assign cin   = i_sub | i_carry;
    assign bit_p = i_add1 ^ b_eff;
    assign bit_g = i_add1 & b_eff;

    always_comb begin
        grp_g   = '0;
        grp_p   = '1;
        grp_c   = '0;
        sum_d   = '0;
        la_term = 1'b0;
        la_prod = 1'b0;
        bit_c   = 1'b0;

        // Group generate/propagate, folded LSB to MSB within each group.
        for (int k = 0; k < G_WIDTH; k++) begin
            grp_g[k / G_GROUP] = bit_g[k] | (bit_p[k] & grp_g[k / G_GROUP]);
            grp_p[k / G_GROUP] = grp_p[k / G_GROUP] & bit_p[k];
        end

        // Second level: every group carry is a flat sum-of-products of the
        // lower groups' G/P terms and cin, so no carry ripples between groups.
        grp_c[0] = cin;
        for (int j = 0; j < NG; j++) begin
            la_term = grp_g[j];
            la_prod = grp_p[j];
            for (int m = j - 1; m >= 0; m--) begin
                la_term = la_term | (la_prod & grp_g[m]);
                la_prod = la_prod & grp_p[m];
            end
            grp_c[j + 1] = la_term | (la_prod & cin);
        end

        // Bit carries inside a group start from that group's lookahead carry.
        for (int k = 0; k < G_WIDTH; k++) begin
            if ((k % G_GROUP) == 0) begin
                bit_c = grp_c[k / G_GROUP];
            end
            sum_d[k] = bit_p[k] ^ bit_c;
            bit_c    = bit_g[k] | (bit_p[k] & bit_c);
        end
    end

    assign ovf_d = (i_add1[G_WIDTH-1] == b_eff[G_WIDTH-1]) &
                   (sum_d[G_WIDTH-1] != i_add1[G_WIDTH-1]);

    // ------------------------------------------------------------------
    // Pipeline with collapsing bubbles
    // ------------------------------------------------------------------
    logic [G_STAGES-1:0] v_q;
    logic [G_STAGES-1:0] load;
    logic [G_WIDTH:0]    res_q [G_STAGES];
    logic [G_STAGES-1:0] ovf_q;
    logic                rdy_en_q;
    logic                accept;

    // A stage can load if it is empty or if the stage after it moves on;
    // any empty stage therefore opens the path all the way to the input.
    always_comb begin
        load       = '0;
        load[LAST] = ~v_q[LAST] | i_ready;
        for (int s = LAST - 1; s >= 0; s--) begin
            load[s] = ~v_q[s] | load[s + 1];
        end
    end

    // rdy_en_q holds o_ready low during reset and for the release cycle.
    assign o_ready = rdy_en_q & load[0];
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en_q <= 1'b0;
            v_q      <= '0;
            ovf_q    <= '0;
            for (int s = 0; s < G_STAGES; s++) begin
                res_q[s] <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            if (load[0]) begin
                v_q[0] <= accept;
                if (accept) begin
                    res_q[0] <= {grp_c[NG], sum_d};
                    ovf_q[0] <= ovf_d;
                end
            end
            for (int s = 1; s < G_STAGES; s++) begin
                if (load[s]) begin
                    v_q[s] <= v_q[s - 1];
                    if (v_q[s - 1]) begin
                        res_q[s] <= res_q[s - 1];
                        ovf_q[s] <= ovf_q[s - 1];
                    end
                end
            end
        end
    end

    assign o_valid    = v_q[LAST];
    assign o_result   = res_q[LAST];
    assign o_overflow = ovf_q[LAST];

`ifdef CLA_ADDER_PIPE_STATS_EN
    logic [15:0] txn_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            txn_q <= '0;
        end else if (o_valid & i_ready) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign o_txn_count = txn_q;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_carry_lookahead_adder_pipe
//   Directed bench for carry_lookahead_adder_pipe. One 8-bit, 4-bit-group,
//   2-stage instance covers reset, add/sub vectors, backpressure and reset
//   during traffic; two 3-bit, 2-bit-group instances (1 and 3 stages) are
//   swept over every operand/mode/carry combination against an arithmetic
//   model. Define CLA_ADDER_PIPE_STATS_EN to also check the transfer counter.
// -----------------------------------------------------------------------------
module tb_carry_lookahead_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic       m_valid, m_ready, m_c, m_sub, m_ovalid, m_iready, m_ovf;
    logic [7:0] m_a, m_b;
    logic [8:0] m_res;

    // 3-bit instances share inputs
    logic       s_valid, s_c, s_sub, s_iready;
    logic [2:0] s_a, s_b;
    logic       d1_ready, d1_valid, d1_ovf;
    logic [3:0] d1_res;
    logic       d3_ready, d3_valid, d3_ovf;
    logic [3:0] d3_res;

`ifdef CLA_ADDER_PIPE_STATS_EN
    logic [15:0] m_cnt, d1_cnt, d3_cnt;
`endif

    carry_lookahead_adder_pipe #(.G_WIDTH(8), .G_GROUP(4), .G_STAGES(2)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(m_valid), .o_ready(m_ready),
        .i_add1(m_a), .i_add2(m_b), .i_carry(m_c), .i_sub(m_sub),
        .o_valid(m_ovalid), .i_ready(m_iready), .o_result(m_res), .o_overflow(m_ovf)
`ifdef CLA_ADDER_PIPE_STATS_EN
        , .o_txn_count(m_cnt)
`endif
    );

    carry_lookahead_adder_pipe #(.G_WIDTH(3), .G_GROUP(2), .G_STAGES(1)) u_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(d1_ready),
        .i_add1(s_a), .i_add2(s_b), .i_carry(s_c), .i_sub(s_sub),
        .o_valid(d1_valid), .i_ready(s_iready), .o_result(d1_res), .o_overflow(d1_ovf)
`ifdef CLA_ADDER_PIPE_STATS_EN
        , .o_txn_count(d1_cnt)
`endif
    );

    carry_lookahead_adder_pipe #(.G_WIDTH(3), .G_GROUP(2), .G_STAGES(3)) u_s3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(d3_ready),
        .i_add1(s_a), .i_add2(s_b), .i_carry(s_c), .i_sub(s_sub),
        .o_valid(d3_valid), .i_ready(s_iready), .o_result(d3_res), .o_overflow(d3_ovf)
`ifdef CLA_ADDER_PIPE_STATS_EN
        , .o_txn_count(d3_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // {overflow, carry_out, sum} for the 3-bit instances
    function automatic logic [4:0] model3(input logic [2:0] a, input logic [2:0] b,
                                          input logic c, input logic sub);
        logic [2:0] be;
        logic [3:0] full;
        logic       ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + (sub ? 4'd1 : {3'b000, c});
        ovf  = (a[2] == be[2]) && (full[2] != a[2]);
        return {ovf, full};
    endfunction

    // One isolated operation on the 8-bit instance, checking latency too.
    task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic sub,
                              input logic [8:0] exp_res, input logic exp_ovf);
        @(negedge clk);
        m_iready = 1'b1;
        m_valid  = 1'b1;
        m_a = a; m_b = b; m_c = c; m_sub = sub;
        #1;
        check_eq({tag, " ready"}, m_ready, 1);
        @(negedge clk);
        // Changing inputs after accept must not disturb the operation in flight.
        m_valid = 1'b0;
        m_a = ~a; m_b = ~b; m_c = ~c; m_sub = ~sub;
        check_eq({tag, " early valid"}, m_ovalid, 0);
        @(negedge clk);
        check_eq({tag, " valid"}, m_ovalid, 1);
        check_eq({tag, " result"}, m_res, exp_res);
        check_eq({tag, " ovf"}, m_ovf, exp_ovf);
        @(negedge clk);
        check_eq({tag, " drained"}, m_ovalid, 0);
    endtask

    logic [7:0] bp_a   [6];
    logic [7:0] bp_b   [6];
    logic       bp_c   [6];
    logic       bp_sub [6];
    logic [8:0] bp_res [6];
    logic       bp_ovf [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   sent, recv, inflight, stall_left, acc, xfer, r1, r3;
        bit   seen, saw_low;
        logic [4:0] exp5;
        logic [4:0] q1 [$];
        logic [4:0] q3 [$];
        logic [7:0] vec;

        bp_a   = '{8'h01, 8'h10, 8'h40, 8'hAA, 8'hC8, 8'h00};
        bp_b   = '{8'h02, 8'h20, 8'h40, 8'h55, 8'hC8, 8'h01};
        bp_c   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bp_sub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bp_res = '{9'h003, 9'h031, 9'h080, 9'h155, 9'h190, 9'h0FF};
        bp_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // ---------------- reset ----------------
        rst_n    = 1'b0;
        m_valid  = 1'b1;
        m_iready = 1'b1;
        m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_sub = 1'b0;
        s_valid  = 1'b0;
        s_iready = 1'b1;
        s_a = 3'd0; s_b = 3'd0; s_c = 1'b0; s_sub = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst valid", m_ovalid, 0);
        check_eq("rst result", m_res, 0);
        check_eq("rst ovf", m_ovf, 0);
        check_eq("rst ready", m_ready, 0);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        #1;
        check_eq("release ready same cycle", m_ready, 0);
        @(negedge clk);
        check_eq("release ready next cycle", m_ready, 1);

        // ---------------- add / sub ----------------
        run_single("add FF+01",    8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0);
        run_single("add 7F+01",    8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1);
        run_single("add 0F+F0+c",  8'h0F, 8'hF0, 1'b1, 1'b0, 9'h100, 1'b0);
        run_single("add 80+80",    8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1);
        run_single("sub 05-06",    8'h05, 8'h06, 1'b0, 1'b1, 9'h0FF, 1'b0);
        run_single("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1);
        run_single("sub 33-33 c1", 8'h33, 8'h33, 1'b1, 1'b1, 9'h100, 1'b0);

        // ---------------- backpressure ----------------
        sent = 0; recv = 0; inflight = 0; stall_left = 0;
        seen = 1'b0; saw_low = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            @(negedge clk);
            if (m_ovalid && !seen) begin
                seen       = 1'b1;
                stall_left = 4;
            end
            m_iready = (stall_left == 0);
            if (sent < 6) begin
                m_valid = 1'b1;
                m_a = bp_a[sent]; m_b = bp_b[sent]; m_c = bp_c[sent]; m_sub = bp_sub[sent];
            end else begin
                m_valid = 1'b0;
                m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_sub = 1'b0;
            end
            #1;
            // With bubbles collapsing, input is refused only when every stage
            // holds an operation and the consumer is stalled.
            check_eq("bp ready", m_ready, (inflight < 2) || m_iready);
            if (!m_ready) saw_low = 1'b1;
            if (m_ovalid) begin
                if (recv < 6) begin
                    check_eq("bp result", m_res, bp_res[recv]);
                    check_eq("bp ovf", m_ovf, bp_ovf[recv]);
                end else begin
                    check_eq("bp extra valid", m_ovalid, 0);
                end
            end
            acc  = (m_valid && m_ready) ? 1 : 0;
            xfer = (m_ovalid && m_iready) ? 1 : 0;
            @(posedge clk);
            sent     += acc;
            recv     += xfer;
            inflight += acc - xfer;
            if (stall_left > 0) stall_left--;
        end
        check_eq("bp received", recv, 6);
        check_eq("bp ready dropped", saw_low, 1);
        m_valid  = 1'b0;
        m_iready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("bp no duplicate", m_ovalid, 0);
        end

        // ---------------- reset with ops in flight ----------------
        @(negedge clk);
        m_iready = 1'b1;
        m_valid  = 1'b1;
        m_a = 8'h12; m_b = 8'h34; m_c = 1'b0; m_sub = 1'b0;
        @(negedge clk);
        m_a = 8'h56; m_b = 8'h78;
        @(negedge clk);
        m_valid = 1'b0;
        check_eq("midrst valid before", m_ovalid, 1);
        check_eq("midrst result before", m_res, 9'h046);
        rst_n = 1'b0;
        #1;
        check_eq("midrst valid", m_ovalid, 0);
        check_eq("midrst result", m_res, 0);
        check_eq("midrst ready", m_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("midrst no output", m_ovalid, 0);
        end

        // ---------------- exhaustive 3-bit ----------------
        r1 = 0; r3 = 0;
        s_iready = 1'b1;
        for (int idx = 0; idx < 256 + 8; idx++) begin
            @(negedge clk);
            if (idx < 256) begin
                vec     = idx[7:0];
                s_valid = 1'b1;
                s_a = vec[2:0]; s_b = vec[5:3]; s_sub = vec[6]; s_c = vec[7];
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (s_valid && d1_ready) q1.push_back(model3(s_a, s_b, s_c, s_sub));
            if (s_valid && d3_ready) q3.push_back(model3(s_a, s_b, s_c, s_sub));
            if (d1_valid) begin
                if (q1.size() == 0) begin
                    check_eq("x1 unexpected valid", d1_valid, 0);
                end else begin
                    exp5 = q1.pop_front();
                    check_eq("x1 result", {d1_ovf, d1_res}, exp5);
                    r1++;
                end
            end
            if (d3_valid) begin
                if (q3.size() == 0) begin
                    check_eq("x3 unexpected valid", d3_valid, 0);
                end else begin
                    exp5 = q3.pop_front();
                    check_eq("x3 result", {d3_ovf, d3_res}, exp5);
                    r3++;
                end
            end
        end
        check_eq("x1 count", r1, 256);
        check_eq("x3 count", r3, 256);
`ifdef CLA_ADDER_PIPE_STATS_EN
        check_eq("x1 txn count", d1_cnt, 256);
        check_eq("x3 txn count", d3_cnt, 256);
        check_eq("main txn count after reset", m_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
